// File: rtl/bresenham_line_engine.sv
// bresenham_line_engine: all-octant integer Bresenham line drawer, one pixel per clock.
// Uses a level start/done handshake. Once o_done is raised it stays high until i_start drops.
// Optional feature macro: CLIP_EN. When it is defined, pixels at or beyond SCREEN_W/SCREEN_H are
// not plotted. Stepping and cycle timing are the same with or without it.
module bresenham_line_engine #(
  parameter int XW       = 9,
  parameter int YW       = 8,
  parameter int CW       = 3,
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic [XW-1:0] i_x0,
  input  logic [YW-1:0] i_y0,
  input  logic [XW-1:0] i_x1,
  input  logic [YW-1:0] i_y1,
  input  logic [CW-1:0] i_color,
  input  logic          i_start,
  output logic          o_done,
  output logic          o_busy,
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y,
  output logic [CW-1:0] o_color,
  output logic          o_plot
);

  localparam int W = ((XW > YW) ? XW : YW) + 3;

`ifdef CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, INIT, DRAW, DONE} state_t;

  state_t              state;
  logic [XW-1:0]       x0_q, x1_q;
  logic [YW-1:0]       y0_q, y1_q;
  logic [CW-1:0]       col_q;
  logic                sx, sy;
  logic signed [W-1:0] dx, dy, err;

  logic signed [W-1:0] ddx, ddy, adx, ady, e2, err_n;
  logic                step_x, step_y, at_end, init_vis, next_vis;
  logic [XW-1:0]       nx;
  logic [YW-1:0]       ny;

  // Endpoint deltas for INIT and the per-pixel step for DRAW. o_x/o_y hold the current pixel.
  always_comb begin
    ddx    = W'(x1_q) - W'(x0_q);
    ddy    = W'(y1_q) - W'(y0_q);
    adx    = (ddx < 0) ? -ddx : ddx;
    ady    = (ddy < 0) ? -ddy : ddy;
    e2     = err <<< 1;
    step_x = (e2 >= dy);
    step_y = (e2 <= dx);
    err_n  = err + (step_x ? dy : '0) + (step_y ? dx : '0);
    nx     = o_x;
    ny     = o_y;
    if (step_x) nx = sx ? (o_x + XW'(1)) : (o_x - XW'(1));
    if (step_y) ny = sy ? (o_y + YW'(1)) : (o_y - YW'(1));
    at_end   = (o_x == x1_q) && (o_y == y1_q);
    init_vis = !CLIP || ((int'(x0_q) < SCREEN_W) && (int'(y0_q) < SCREEN_H));
    next_vis = !CLIP || ((int'(nx) < SCREEN_W) && (int'(ny) < SCREEN_H));
  end

  // Control FSM. All outputs are registered. o_plot is loaded together with the pixel it qualifies.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= IDLE;
      x0_q    <= '0;
      y0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      col_q   <= '0;
      sx      <= 1'b0;
      sy      <= 1'b0;
      dx      <= '0;
      dy      <= '0;
      err     <= '0;
      o_done  <= 1'b0;
      o_busy  <= 1'b0;
      o_x     <= '0;
      o_y     <= '0;
      o_color <= '0;
      o_plot  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            x0_q   <= i_x0;
            y0_q   <= i_y0;
            x1_q   <= i_x1;
            y1_q   <= i_y1;
            col_q  <= i_color;
            o_busy <= 1'b1;
            state  <= INIT;
          end
        end
        INIT: begin
          dx      <= adx;
          dy      <= -ady;
          err     <= adx - ady;
          sx      <= (x0_q < x1_q);
          sy      <= (y0_q < y1_q);
          o_x     <= x0_q;
          o_y     <= y0_q;
          o_color <= col_q;
          o_plot  <= init_vis;
          state   <= DRAW;
        end
        DRAW: begin
          if (at_end) begin
            o_plot <= 1'b0;
            o_busy <= 1'b0;
            o_done <= 1'b1;
            state  <= DONE;
          end else begin
            err    <= err_n;
            o_x    <= nx;
            o_y    <= ny;
            o_plot <= next_vis;
          end
        end
        DONE: begin
          if (!i_start) begin
            o_done <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bresenham_line_engine.sv
// Testbench for bresenham_line_engine. It uses a table of lines with explicit pixel lists and a
// queue scoreboard. Hand-written sequences cover held start, reset mid-line, long lines and clipping.
module tb_bresenham_line_engine;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic [8:0] i_x0 = '0, i_x1 = '0;
  logic [7:0] i_y0 = '0, i_y1 = '0;
  logic [2:0] i_color = '0;
  logic       i_start = 1'b0;
  logic       o_done, o_busy, o_plot;
  logic [8:0] o_x;
  logic [7:0] o_y;
  logic [2:0] o_color;

  int checks = 0;
  int errors = 0;

  typedef struct {int x; int y; int c;} pix_t;
  pix_t q[$];

  typedef struct {
    int x0; int y0; int x1; int y1; int c; int n;
    int px[8]; int py[8];
  } line_t;
  line_t tbl[5];

  bresenham_line_engine #(.XW(9), .YW(8), .CW(3), .SCREEN_W(320), .SCREEN_H(240)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_x0(i_x0), .i_y0(i_y0), .i_x1(i_x1), .i_y1(i_y1),
    .i_color(i_color), .i_start(i_start),
    .o_done(o_done), .o_busy(o_busy),
    .o_x(o_x), .o_y(o_y), .o_color(o_color), .o_plot(o_plot)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic bit vis(input int x, input int y);
`ifdef CLIP_EN
    return (x < 320) && (y < 240);
`else
    return 1'b1;
`endif
  endfunction

  task automatic push_pix(input int x, input int y, input int c);
    pix_t p;
    p.x = x; p.y = y; p.c = c;
    if (vis(x, y)) q.push_back(p);
  endtask

  // Drives one request and stays in it until o_done is high or the cycle budget runs out.
  // Each plotted pixel is popped from the scoreboard and compared.
  task automatic run_line(input int x0, input int y0, input int x1, input int y1,
                          input int c, input int n, input string nm);
    int cyc = 0, first = -1, seen = 0, done_cyc = -1;
    bit gap = 0, prev_plot = 0, last_plot = 0;
    pix_t p;
    i_x0 = 9'(x0); i_y0 = 8'(y0); i_x1 = 9'(x1); i_y1 = 8'(y1); i_color = 3'(c);
    i_start = 1'b1;
    while (cyc < n + 20 && done_cyc < 0) begin
      @(negedge i_clk);
      cyc++;
      if (cyc == 1) begin
        chk({nm, "_init_busy"}, int'(o_busy), 1);
        chk({nm, "_init_plot"}, int'(o_plot), 0);
      end
      if (o_plot) begin
        if (seen == 0) first = cyc;
        seen++;
        if (q.size() == 0) chk({nm, "_extra_pixel"}, seen, 0);
        else begin
          p = q.pop_front();
          chk({nm, "_x"}, int'(o_x), p.x);
          chk({nm, "_y"}, int'(o_y), p.y);
          chk({nm, "_color"}, int'(o_color), p.c);
        end
      end else if (seen > 0 && !o_done) gap = 1;
      if (o_done) begin
        done_cyc = cyc;
        last_plot = prev_plot;
      end
      prev_plot = o_plot;
    end
    chk({nm, "_done_cycle"}, done_cyc, n + 2);
    chk({nm, "_missing_pixels"}, q.size(), 0);
    chk({nm, "_busy_at_done"}, int'(o_busy), 0);
    if (vis(x0, y0)) chk({nm, "_first_latency"}, first, 2);
`ifndef CLIP_EN
    chk({nm, "_gap"}, int'(gap), 0);
    chk({nm, "_done_after_last"}, int'(last_plot), 1);
`endif
    q.delete();
  endtask

  task automatic finish_line(input string nm);
    i_start = 1'b0;
    @(negedge i_clk);
    chk({nm, "_done_drop"}, int'(o_done), 0);
    @(negedge i_clk);
    chk({nm, "_idle_busy"}, int'(o_busy), 0);
  endtask

  initial begin
    tbl[0] = '{0, 0, 3, 0, 7, 4, '{0, 1, 2, 3, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0}};
    tbl[1] = '{0, 0, 4, 2, 3, 5, '{0, 1, 2, 3, 4, 0, 0, 0}, '{0, 1, 1, 2, 2, 0, 0, 0}};
    tbl[2] = '{5, 5, 2, 8, 6, 4, '{5, 4, 3, 2, 0, 0, 0, 0}, '{5, 6, 7, 8, 0, 0, 0, 0}};
    tbl[3] = '{0, 0, 1, 3, 1, 4, '{0, 0, 1, 1, 0, 0, 0, 0}, '{0, 1, 2, 3, 0, 0, 0, 0}};
    tbl[4] = '{7, 4, 0, 1, 4, 8, '{7, 6, 5, 4, 3, 2, 1, 0}, '{4, 4, 3, 3, 2, 2, 1, 1}};

    // Reset state
    repeat (2) @(negedge i_clk);
    chk("rst_done", int'(o_done), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_plot", int'(o_plot), 0);
    chk("rst_xyc", int'({o_x, o_y, o_color}), 0);
    i_reset = 1'b0;
    @(negedge i_clk);

    // Table-driven lines
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < tbl[i].n; k++) push_pix(tbl[i].px[k], tbl[i].py[k], tbl[i].c);
      run_line(tbl[i].x0, tbl[i].y0, tbl[i].x1, tbl[i].y1, tbl[i].c, tbl[i].n, $sformatf("line%0d", i));
      finish_line($sformatf("line%0d", i));
    end

    // A degenerate line gives one pixel. Holding start afterwards must not start another line.
    push_pix(234, 123, 5);
    run_line(234, 123, 234, 123, 5, 1, "degen");
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      chk("hold_done", int'(o_done), 1);
      chk("hold_plot", int'(o_plot), 0);
      chk("hold_busy", int'(o_busy), 0);
    end
    chk("hold_x", int'(o_x), 234);
    finish_line("degen");

    // Reset is asserted during the third DRAW cycle.
    begin
      int cyc = 0, seen = 0;
      pix_t p;
      for (int k = 0; k < 3; k++) push_pix(k, 0, 2);
      i_x0 = 9'd0; i_y0 = 8'd0; i_x1 = 9'd10; i_y1 = 8'd0; i_color = 3'd2; i_start = 1'b1;
      while (seen < 3 && cyc < 20) begin
        @(negedge i_clk);
        cyc++;
        if (o_plot) begin
          seen++;
          p = q.pop_front();
          chk("rstmid_x", int'(o_x), p.x);
        end
      end
      chk("rstmid_reach", seen, 3);
      i_reset = 1'b1;
      i_start = 1'b0;
      @(negedge i_clk);
      chk("rstmid_plot", int'(o_plot), 0);
      chk("rstmid_busy", int'(o_busy), 0);
      chk("rstmid_done", int'(o_done), 0);
      chk("rstmid_xyc", int'({o_x, o_y, o_color}), 0);
      i_reset = 1'b0;
      q.delete();
      @(negedge i_clk);
    end
    for (int k = 0; k < 3; k++) push_pix(2, 3 - k, 3);
    run_line(2, 3, 2, 1, 3, 3, "after_rst");
    finish_line("after_rst");

    // Long lines at full coordinate range
    for (int k = 0; k < 512; k++) push_pix(k, 7, 2);
    run_line(0, 7, 511, 7, 2, 512, "horiz");
    finish_line("horiz");
    for (int k = 0; k < 256; k++) push_pix(511 - k, 255 - k, 5);
    run_line(511, 255, 256, 0, 5, 256, "diag");
    finish_line("diag");
    for (int k = 0; k < 256; k++) push_pix(300, k, 1);
    run_line(300, 0, 300, 255, 1, 256, "vert");
    finish_line("vert");

    // Line crossing the right screen edge. Only x=318 and x=319 are plotted when clipping is built in.
    for (int k = 318; k <= 322; k++) push_pix(k, 5, 6);
    run_line(318, 5, 322, 5, 6, 5, "clip");
    finish_line("clip");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
